// File: rtl/otter_rf_pkg.sv
// Shared types and defaults for the OTTER register file with hazard scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package otter_rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, set by ID reservations, cleared by WB writes.
// Latency: set/clear take effect at the next posedge; rd_pending lookup is combinational.
// Backpressure: none; updates are only accepted while ready=1 and the zero register is never tracked.
module rf_scoreboard #(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ready,
  input  logic                          wr_en,
  input  logic [$clog2(NREGS)-1:0]      wr_addr,
  input  logic                          rsv_en,
  input  logic [$clog2(NREGS)-1:0]      rsv_addr,
  input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
  output logic [NRD-1:0]                rd_pending
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Next pending vector: the write clears first, so a same-address reservation overrides it
  always_comb begin
    pending_d = pending_q;
    if (ready) begin
      if (wr_en && !is_zero(wr_addr)) begin
        pending_d[wr_addr] = 1'b0;
      end
      if (rsv_en && !is_zero(rsv_addr)) begin
        pending_d[rsv_addr] = 1'b1;
      end
    end
  end

  // Pending register; reset drops every outstanding reservation
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Per-port lookup; a writeback in the same cycle already resolves the hazard
  for (genvar i = 0; i < NRD; i++) begin : g_pend
    logic [AW-1:0] a;
    assign a             = rd_addr[i*AW +: AW];
    assign rd_pending[i] = ready && pending_q[a] && !(wr_en && (wr_addr == a));
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write-through bypass, zero register and post-reset clear walk.
// Latency: reads are combinational (0 cycles); writes and reservations land at the next posedge.
// Backpressure: busy=1 for NREGS cycles after reset; all requests are dropped while busy.
module regfile_scoreboard
  import otter_rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_pending,
  input  logic                          wr_en,
  input  logic [$clog2(NREGS)-1:0]      wr_addr,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          rsv_en,
  input  logic [$clog2(NREGS)-1:0]      rsv_addr,
  output logic                          busy
);

  localparam int            AW       = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_t     state_q;
  rf_state_t     state_d;
  logic [AW-1:0] clr_idx_q;
  logic [AW-1:0] clr_idx_d;
  logic          ready;

  logic [XLEN-1:0] mem_q [NREGS];

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // State register: reset from any state restarts the clear walk at index 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next state: walk every index once, leave CLEAR after the last one
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      RF_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d = RF_READY;
        end
      end
      RF_READY: begin
        state_d = RF_READY;
      end
    endcase
  end

  // Outputs of the clear FSM
  always_comb begin
    busy  = (state_q == RF_CLEAR);
    ready = (state_q == RF_READY);
  end

  // Storage: clear walk zeroes one entry per cycle, otherwise accept the writeback
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == RF_CLEAR) begin
        mem_q[clr_idx_q] <= '0;
      end else if (wr_en && !is_zero(wr_addr)) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  // Read ports: zero register beats bypass, bypass beats storage, everything reads 0 while clearing
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          byp;
    assign a   = rd_addr[i*AW +: AW];
    assign byp = wr_en && (wr_addr == a) && !is_zero(wr_addr);
    assign rd_data[i*XLEN +: XLEN] = (!ready || is_zero(a)) ? '0 :
                                     (byp ? wr_data : mem_q[a]);
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rd_addr    (rd_addr),
    .rd_pending (rd_pending)
  );

endmodule
